// File: rtl/bug_ctl.sv
// rtl/bug_ctl.sv - frame-rate motion, bounce, hit detection and respawn for the bug sprite
module bug_ctl #(
  parameter int H_RES         = 1024,
  parameter int V_RES         = 768,
  parameter int WIDTH         = 53,
  parameter int HEIGHT        = 54,
  parameter int STEP          = 2,
  parameter int TURN_FRAMES   = 64,
  parameter int FREEZE_FRAMES = 60,
  parameter int START_X       = 100,
  parameter int START_Y       = 100
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] x_bugpos,
  output logic [11:0] y_bugpos,
  output logic [1:0]  rotation,
  output logic        hit,
  output logic [7:0]  hit_count
);

  localparam int TW = $clog2(TURN_FRAMES + 1);
  localparam int FW = $clog2(FREEZE_FRAMES + 1);
  localparam logic [11:0] XMAX12 = 12'(H_RES - WIDTH);
  localparam logic [11:0] YMAX12 = 12'(V_RES - HEIGHT);
  localparam logic [9:0]  XMAX10 = 10'(H_RES - WIDTH);
  localparam logic [9:0]  YMAX10 = 10'(V_RES - HEIGHT);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_FRAMES - 1);

  typedef enum logic [1:0] {S_MOVE, S_HIT, S_RESPAWN} state_t;

  state_t          state_q;
  logic [11:0]     x_q, y_q;
  logic [1:0]      dir_q;
  logic            hit_q;
  logic [7:0]      cnt_q;
  logic [TW-1:0]   turn_q;
  logic [FW-1:0]   frz_q;
  logic [15:0]     lfsr_q;
  logic            vblnk_d_q, ml_d_q;

  logic            tick, click, on_bug, blocked;
  logic [1:0]      dir_d;
  logic [TW-1:0]   turn_d;
  logic [11:0]     x_d, y_d;
  logic [9:0]      rx, ry;
  logic [15:0]     lfsr_d;

  assign tick   = vblnk & ~vblnk_d_q;
  assign click  = mouse_left & ~ml_d_q;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign on_bug = (xpos >= x_q) && ({1'b0, xpos} < ({1'b0, x_q} + 13'(WIDTH))) &&
                  (ypos >= y_q) && ({1'b0, ypos} < ({1'b0, y_q} + 13'(HEIGHT)));

  // The random turn is taken first so the bounce test sees the new heading.
  always_comb begin
    dir_d   = dir_q;
    turn_d  = turn_q + TW'(1);
    x_d     = x_q;
    y_d     = y_q;
    blocked = 1'b0;
    if (turn_q == TURN_LAST) begin
      turn_d = '0;
      dir_d  = lfsr_q[1:0];
    end
    case (dir_d)
      2'b00: begin blocked = (y_q < STEP12);           y_d = y_q - STEP12; end
      2'b01: begin blocked = (x_q + STEP12 > XMAX12);  x_d = x_q + STEP12; end
      2'b10: begin blocked = (y_q + STEP12 > YMAX12);  y_d = y_q + STEP12; end
      default: begin blocked = (x_q < STEP12);         x_d = x_q - STEP12; end
    endcase
  end

  assign rx = (lfsr_q[9:0]  > XMAX10) ? lfsr_q[9:0]  - XMAX10 : lfsr_q[9:0];
  assign ry = (lfsr_q[15:6] > YMAX10) ? lfsr_q[15:6] - YMAX10 : lfsr_q[15:6];

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= S_MOVE;
      x_q       <= 12'(START_X);
      y_q       <= 12'(START_Y);
      dir_q     <= 2'b00;
      hit_q     <= 1'b0;
      cnt_q     <= 8'd0;
      turn_q    <= '0;
      frz_q     <= '0;
      lfsr_q    <= 16'hACE1;
      vblnk_d_q <= 1'b1;
      ml_d_q    <= 1'b1;
    end else begin
      vblnk_d_q <= vblnk;
      ml_d_q    <= mouse_left;
      lfsr_q    <= lfsr_d;
      hit_q     <= 1'b0;
      case (state_q)
        S_MOVE: begin
          if (click && on_bug) begin
            hit_q   <= 1'b1;
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            frz_q   <= FW'(FREEZE_FRAMES);
            state_q <= S_HIT;
          end else if (tick) begin
            turn_q <= turn_d;
            if (blocked) begin
              dir_q <= dir_d ^ 2'b10;
            end else begin
              dir_q <= dir_d;
              x_q   <= x_d;
              y_q   <= y_d;
            end
          end
        end
        S_HIT: begin
          if (tick) begin
            frz_q <= frz_q - FW'(1);
            if (frz_q <= FW'(1)) state_q <= S_RESPAWN;
          end
        end
        S_RESPAWN: begin
          x_q     <= {2'b00, rx};
          y_q     <= {2'b00, ry};
          dir_q   <= lfsr_q[1:0];
          turn_q  <= '0;
          state_q <= S_MOVE;
        end
        default: state_q <= S_MOVE;
      endcase
    end
  end

  assign x_bugpos  = x_q;
  assign y_bugpos  = y_q;
  assign rotation  = dir_q;
  assign hit       = hit_q;
  assign hit_count = cnt_q;

endmodule

// File: tb/tb_bug_ctl.sv
// tb/tb_bug_ctl.sv - table vectors plus hand sequences for bug_ctl, scoreboard-checked
module tb_bug_ctl;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        vblnk = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] xpos = 12'd0, ypos = 12'd0;
  logic [11:0] x_bugpos, y_bugpos, x4, y4;
  logic [1:0]  rotation, rot4;
  logic        hit, hit4;
  logic [7:0]  hit_count, cnt4;

  always #5 pclk = ~pclk;

  bug_ctl dut (
    .pclk(pclk), .reset(reset), .vblnk(vblnk), .mouse_left(mouse_left),
    .xpos(xpos), .ypos(ypos), .x_bugpos(x_bugpos), .y_bugpos(y_bugpos),
    .rotation(rotation), .hit(hit), .hit_count(hit_count)
  );

  bug_ctl #(.START_Y(4)) dut4 (
    .pclk(pclk), .reset(reset), .vblnk(vblnk), .mouse_left(mouse_left),
    .xpos(xpos), .ypos(ypos), .x_bugpos(x4), .y_bugpos(y4),
    .rotation(rot4), .hit(hit4), .hit_count(cnt4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int hit_pulses = 0;

  always @(negedge pclk) if (hit) hit_pulses <= hit_pulses + 1;

  // Reference LFSR; lfsr_prev is the value the DUT used at the latest edge.
  logic [15:0] lfsr_m = 16'hACE1, lfsr_prev = 16'hACE1;
  always @(posedge pclk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= reset ? 16'hACE1 :
                 {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  typedef struct {
    string name;
    int x; int y; int rot; int hit; int cnt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int kind; int px; int py;
    int ex; int ey; int erot; int ehit; int ecnt;
  } vec_t;
  vec_t tv[17];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input string name, input int x, y, rot, h, cnt);
    exp_t e;
    e.name = name; e.x = x; e.y = y; e.rot = rot; e.hit = h; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: output observed with no expectation queued");
    end else begin
      e = sb.pop_front();
      if ({x_bugpos, y_bugpos, rotation, hit, hit_count} !==
          {12'(e.x), 12'(e.y), 2'(e.rot), 1'(e.hit), 8'(e.cnt)}) begin
        n_bad++;
        $display("FAIL %s: got x=%0d y=%0d rot=%0d hit=%0d cnt=%0d, expected x=%0d y=%0d rot=%0d hit=%0d cnt=%0d",
                 e.name, x_bugpos, y_bugpos, rotation, hit, hit_count,
                 e.x, e.y, e.rot, e.hit, e.cnt);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    reset = 1'b1; vblnk = 1'b0; mouse_left = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
  endtask

  task automatic tick();
    @(negedge pclk); vblnk = 1'b1;
    @(negedge pclk); vblnk = 1'b0;
  endtask

  task automatic click(input int cx, input int cy);
    @(negedge pclk); mouse_left = 1'b1; xpos = 12'(cx); ypos = 12'(cy);
    @(negedge pclk); mouse_left = 1'b0;
  endtask

  function automatic void mv(input int x, y, d, output int nx, ny, nd);
    nx = x; ny = y; nd = d;
    case (d)
      0: if (y < 2) nd = 2; else ny = y - 2;
      1: if (x + 2 > 971) nd = 3; else nx = x + 2;
      2: if (y + 2 > 714) nd = 0; else ny = y + 2;
      default: if (x < 2) nd = 1; else nx = x - 2;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int y4e[4] = '{2, 0, 0, 2};
    int r4e[4] = '{0, 0, 2, 2};
    int ex, ey, ed, rx, ry, rd, hp0;
    logic [15:0] l;

    tv[0]  = '{1, 153, 100, 100, 100, 0, 0, 0};
    tv[1]  = '{1, 100, 154, 100, 100, 0, 0, 0};
    tv[2]  = '{1,  99, 100, 100, 100, 0, 0, 0};
    tv[3]  = '{1, 100,  99, 100, 100, 0, 0, 0};
    for (int k = 1; k <= 10; k++) tv[3+k] = '{0, 0, 0, 100, 100 - 2*k, 0, 0, 0};
    tv[14] = '{1, 152, 133, 100, 80, 0, 1, 1};
    tv[15] = '{0,   0,   0, 100, 80, 0, 0, 1};
    tv[16] = '{1, 120, 100, 100, 80, 0, 0, 1};

    do_reset();
    push("reset", 100, 100, 0, 0, 0);
    sb_check();

    for (int i = 0; i < 17; i++) begin
      push($sformatf("vec%0d", i), tv[i].ex, tv[i].ey, tv[i].erot, tv[i].ehit, tv[i].ecnt);
      if (tv[i].kind == 1) click(tv[i].px, tv[i].py);
      else tick();
      sb_check();
    end

    // Edge bounce on both instances and the random turn on tick 64.
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k <= 4) begin
        chk($sformatf("y4_tick%0d", k), int'(y4), y4e[k-1]);
        chk($sformatf("rot4_tick%0d", k), int'(rot4), r4e[k-1]);
      end
      if (k == 50) chk("y_tick50", int'(y_bugpos), 0);
      if (k == 51) begin
        chk("y_tick51", int'(y_bugpos), 0);
        chk("rot_tick51", int'(rotation), 2);
      end
      if (k == 52) chk("y_tick52", int'(y_bugpos), 2);
      if (k == 64) begin
        l = lfsr_prev;
        mv(100, 24, int'(l[1:0]), ex, ey, ed);
        push("turn_tick64", ex, ey, ed, 0, 0);
        sb_check();
        chk("turn_rot_is_lfsr", int'(rotation), int'(l[1:0]));
      end
    end

    // Hit, freeze for 60 ticks, respawn, resume.
    do_reset();
    push("hit_pulse", 100, 100, 0, 1, 1);
    click(120, 120);
    sb_check();
    @(negedge pclk);
    chk("hit_one_cycle", int'(hit), 0);
    for (int k = 1; k <= 59; k++) begin
      tick();
      if (k == 30) begin
        push("click_in_hit", 100, 100, 0, 0, 1);
        click(110, 110);
        sb_check();
      end
    end
    push("frozen_tick59", 100, 100, 0, 0, 1);
    sb_check();
    tick();
    push("frozen_tick60", 100, 100, 0, 0, 1);
    sb_check();
    @(negedge pclk);
    l  = lfsr_prev;
    rx = int'(l[9:0]);  if (rx > 971) rx -= 971;
    ry = int'(l[15:6]); if (ry > 714) ry -= 714;
    rd = int'(l[1:0]);
    push("respawn", rx, ry, rd, 0, 1);
    sb_check();
    chk("respawn_x_range", int'(x_bugpos <= 12'd971), 1);
    chk("respawn_y_range", int'(y_bugpos <= 12'd714), 1);
    mv(rx, ry, rd, ex, ey, ed);
    push("resume_move", ex, ey, ed, 0, 1);
    tick();
    sb_check();

    // Click coinciding with a tick, then reset while frozen.
    do_reset();
    @(negedge pclk);
    vblnk = 1'b1; mouse_left = 1'b1; xpos = 12'd120; ypos = 12'd120;
    @(negedge pclk);
    vblnk = 1'b0; mouse_left = 1'b0;
    push("click_and_tick", 100, 100, 0, 1, 1);
    sb_check();
    push("frozen_after", 100, 100, 0, 0, 1);
    tick();
    sb_check();
    push("ignored_click", 100, 100, 0, 0, 1);
    click(120, 120);
    sb_check();
    @(negedge pclk); reset = 1'b1;
    @(negedge pclk);
    push("reset_in_hit", 100, 100, 0, 0, 0);
    sb_check();
    reset = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    push("move_after_reset", 100, 98, 0, 0, 0);
    tick();
    sb_check();

    // Held button gives one hit; then saturate the counter.
    do_reset();
    hp0 = hit_pulses;
    @(negedge pclk); mouse_left = 1'b1; xpos = 12'd110; ypos = 12'd110;
    tick(); tick(); tick();
    @(negedge pclk); mouse_left = 1'b0;
    @(negedge pclk);
    chk("held_button_pulses", hit_pulses - hp0, 1);
    chk("held_button_count", int'(hit_count), 1);
    for (int h = 2; h <= 256; h++) begin
      for (int k = 0; k < 60; k++) tick();
      @(negedge pclk);
      click(int'(x_bugpos), int'(y_bugpos));
    end
    @(negedge pclk);
    @(negedge pclk);
    chk("count_saturated", int'(hit_count), 255);
    chk("pulses_256", hit_pulses - hp0, 256);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
